seq_divider: RTL and testbench

//  Multi-cycle N-bit integer divider, restoring radix-2, one quotient bit per clock.

---
 rtl/seq_divider.sv | 189 ++++++++++++++++++
 tb/tb_seq_divider.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Multi-cycle restoring radix-2 integer divider. Produces one
//               quotient bit per clock via a trial subtraction, with a
//               start/busy/done handshake. Reports quotient, remainder,
//               ALU-style N/Z/V flags and divide-by-zero.
// Ports       :
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   start        in   request, sampled only in IDLE
//   is_signed    in   1 = two's-complement operands (sampled with start)
//   dividend     in   N-bit dividend (sampled with start)
//   divisor      in   N-bit divisor (sampled with start)
//   busy         out  high from the cycle after acceptance until done
//   done         out  one-cycle pulse, results valid from this cycle
//   quotient     out  N-bit quotient, held until next operation's FIX
//   remainder    out  N-bit remainder, held until next operation's FIX
//   div_by_zero  out  divisor was zero
//   flag_n       out  quotient[N-1]
//   flag_z       out  quotient == 0
//   flag_v       out  signed overflow (most-negative / -1)
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider #(
  parameter int N = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         is_signed,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero,
  output logic         flag_n,
  output logic         flag_z,
  output logic         flag_v
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t         state_q;
  logic [CW-1:0]  count_q;
  logic [N-1:0]   dvd_q;      // dividend magnitude; quotient bits shift in at LSB
  logic [N-1:0]   dsr_q;      // divisor magnitude
  logic [N-1:0]   rem_q;      // partial remainder
  logic           quot_neg_q;
  logic           rem_neg_q;
  logic           ovf_q;
  logic           op_dbz_q;
  logic           busy_q;
  logic           done_q;
  logic [N-1:0]   quot_q;
  logic [N-1:0]   rem_out_q;
  logic           dbz_q;
  logic           n_q;
  logic           z_q;
  logic           v_q;

  // Operand conditioning at acceptance
  logic           w_sa;
  logic           w_sb;
  logic [N-1:0]   w_mag_a;
  logic [N-1:0]   w_mag_b;
  logic           w_ovf;

  assign w_sa    = is_signed & dividend[N-1];
  assign w_sb    = is_signed & divisor[N-1];
  assign w_mag_a = w_sa ? -dividend : dividend;
  assign w_mag_b = w_sb ? -divisor  : divisor;
  assign w_ovf   = is_signed && (dividend == {1'b1, {(N-1){1'b0}}}) && (divisor == '1);

  // One restoring step. The partial remainder is always below 2^(N-1)
  // before the shift, so dropping rem_q[N-1] loses nothing.
  logic [N-1:0]   w_rem_t;
  logic [N:0]     w_diff;
  logic           w_borrow;

  assign w_rem_t  = {rem_q[N-2:0], dvd_q[N-1]};
  assign w_diff   = {1'b0, w_rem_t} - {1'b0, dsr_q};
  assign w_borrow = w_diff[N];

  // Sign-corrected results presented to the output registers in FIX
  logic [N-1:0]   quot_d;
  logic [N-1:0]   rem_d;

  always_comb begin
    quot_d = quot_neg_q ? -dvd_q : dvd_q;
    rem_d  = rem_neg_q  ? -rem_q : rem_q;
    if (op_dbz_q) begin
      quot_d = '1;
      rem_d  = dvd_q;           // raw dividend was latched for this case
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      dvd_q      <= '0;
      dsr_q      <= '0;
      rem_q      <= '0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      ovf_q      <= 1'b0;
      op_dbz_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      quot_q     <= '0;
      rem_out_q  <= '0;
      dbz_q      <= 1'b0;
      n_q        <= 1'b0;
      z_q        <= 1'b0;
      v_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (divisor == '0) begin
              state_q    <= S_FIX;
              op_dbz_q   <= 1'b1;
              dvd_q      <= dividend;
              quot_neg_q <= 1'b0;
              rem_neg_q  <= 1'b0;
              ovf_q      <= 1'b0;
            end else begin
              state_q    <= S_CALC;
              op_dbz_q   <= 1'b0;
              dvd_q      <= w_mag_a;
              dsr_q      <= w_mag_b;
              rem_q      <= '0;
              quot_neg_q <= w_sa ^ w_sb;
              rem_neg_q  <= w_sa;
              ovf_q      <= w_ovf;
              count_q    <= CW'(N - 1);
            end
          end
        end
        S_CALC: begin
          dvd_q   <= {dvd_q[N-2:0], ~w_borrow};
          rem_q   <= w_borrow ? w_rem_t : w_diff[N-1:0];
          count_q <= count_q - CW'(1);
          if (count_q == '0) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          quot_q    <= quot_d;
          rem_out_q <= rem_d;
          dbz_q     <= op_dbz_q;
          n_q       <= quot_d[N-1];
          z_q       <= (quot_d == '0);
          v_q       <= ovf_q;
          busy_q    <= 1'b0;
          state_q   <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_out_q;
  assign div_by_zero = dbz_q;
  assign flag_n      = n_q;
  assign flag_z      = z_q;
  assign flag_v      = v_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_seq_divider
// Description : Self-checking bench for seq_divider (N = 24). Table of
//               directed operations with hand-computed results, followed by
//               handshake, ignored-start and mid-operation reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

  localparam int N  = 24;
  localparam int NV = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         is_signed;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;
  logic         flag_n;
  logic         flag_z;
  logic         flag_v;

  seq_divider #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .flag_n      (flag_n),
    .flag_z      (flag_z),
    .flag_v      (flag_v)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         sgn;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dbz;
    logic         n;
    logic         z;
    logic         v;
    int           lat;
  } vec_t;

  vec_t vecs [NV];

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Issue one operation; return edges from acceptance to the done sample
  // and the number of samples with busy high.
  task automatic do_op(input logic sgn, input logic [N-1:0] a, input logic [N-1:0] b,
                       output int lat, output int bcnt);
    @(negedge clk);
    start     = 1'b1;
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 0;
    bcnt  = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy === 1'b1) bcnt++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int lat;
    int bcnt;
    int dones;

    //            sgn   dividend     divisor      quotient     remainder    dbz   n     z     v     lat
    vecs[0]  = '{1'b0, 24'd100,     24'd7,       24'h00000E,  24'd2,       1'b0, 1'b0, 1'b0, 1'b0, 26};
    vecs[1]  = '{1'b1, 24'hFFFF9C,  24'd7,       24'hFFFFF2,  24'hFFFFFE,  1'b0, 1'b1, 1'b0, 1'b0, 26};
    vecs[2]  = '{1'b1, 24'h800000,  24'hFFFFFF,  24'h800000,  24'h000000,  1'b0, 1'b1, 1'b0, 1'b1, 26};
    vecs[3]  = '{1'b0, 24'h800000,  24'hFFFFFF,  24'h000000,  24'h800000,  1'b0, 1'b0, 1'b1, 1'b0, 26};
    vecs[4]  = '{1'b0, 24'd5,       24'd0,       24'hFFFFFF,  24'd5,       1'b1, 1'b1, 1'b0, 1'b0, 2};
    vecs[5]  = '{1'b0, 24'd9,       24'd3,       24'd3,       24'd0,       1'b0, 1'b0, 1'b0, 1'b0, 26};
    vecs[6]  = '{1'b1, 24'd100,     24'hFFFFF9,  24'hFFFFF2,  24'd2,       1'b0, 1'b1, 1'b0, 1'b0, 26};
    vecs[7]  = '{1'b1, 24'hFFFF9C,  24'hFFFFF9,  24'h00000E,  24'hFFFFFE,  1'b0, 1'b0, 1'b0, 1'b0, 26};
    vecs[8]  = '{1'b1, 24'hFFFFFF,  24'hFFFFFF,  24'd1,       24'd0,       1'b0, 1'b0, 1'b0, 1'b0, 26};
    vecs[9]  = '{1'b0, 24'd3,       24'd10,      24'd0,       24'd3,       1'b0, 1'b0, 1'b1, 1'b0, 26};
    vecs[10] = '{1'b1, 24'hFFFFF0,  24'd0,       24'hFFFFFF,  24'hFFFFF0,  1'b1, 1'b1, 1'b0, 1'b0, 2};
    vecs[11] = '{1'b1, 24'h800000,  24'd1,       24'h800000,  24'd0,       1'b0, 1'b1, 1'b0, 1'b0, 26};
    vecs[12] = '{1'b1, 24'h800000,  24'd2,       24'hC00000,  24'd0,       1'b0, 1'b1, 1'b0, 1'b0, 26};
    vecs[13] = '{1'b0, 24'hFFFFFF,  24'h800001,  24'd1,       24'h7FFFFE,  1'b0, 1'b0, 1'b0, 1'b0, 26};
    vecs[14] = '{1'b0, 24'hFFFFFF,  24'hFFFFFF,  24'd1,       24'd0,       1'b0, 1'b0, 1'b0, 1'b0, 26};
    vecs[15] = '{1'b1, 24'd7,       24'hFFFFFE,  24'hFFFFFD,  24'd1,       1'b0, 1'b1, 1'b0, 1'b0, 26};

    rst       = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy",      32'(busy),        32'd0);
    check("reset done",      32'(done),        32'd0);
    check("reset quotient",  32'(quotient),    32'd0);
    check("reset remainder", 32'(remainder),   32'd0);
    check("reset dbz",       32'(div_by_zero), 32'd0);
    check("reset flags",     {29'd0, flag_n, flag_z, flag_v}, 32'd0);
    rst = 1'b0;

    // Operations run back to back: each start lands in the cycle done is high.
    for (int i = 0; i < NV; i++) begin
      do_op(vecs[i].sgn, vecs[i].a, vecs[i].b, lat, bcnt);
      check($sformatf("v%0d latency", i),   32'(lat),          32'(vecs[i].lat));
      check($sformatf("v%0d busy", i),      32'(bcnt),         32'(vecs[i].lat - 1));
      check($sformatf("v%0d quotient", i),  32'(quotient),     32'(vecs[i].q));
      check($sformatf("v%0d remainder", i), 32'(remainder),    32'(vecs[i].r));
      check($sformatf("v%0d dbz", i),       32'(div_by_zero),  32'(vecs[i].dbz));
      check($sformatf("v%0d flag_n", i),    32'(flag_n),       32'(vecs[i].n));
      check($sformatf("v%0d flag_z", i),    32'(flag_z),       32'(vecs[i].z));
      check($sformatf("v%0d flag_v", i),    32'(flag_v),       32'(vecs[i].v));
    end

    // Starts during CALC and during DONE are dropped, not queued.
    @(negedge clk);
    start     = 1'b1;
    is_signed = 1'b0;
    dividend  = 24'hFFFFFF;
    divisor   = 24'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dones = 0;
    lat   = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        dones++;
        lat = c;
      end
      if (c == 9 || c == 25) begin
        start    = 1'b1;
        dividend = 24'd6;
        divisor  = 24'd2;
      end else begin
        start = 1'b0;
      end
    end
    check("ignore done count", 32'(dones),     32'd1);
    check("ignore latency",    32'(lat),       32'd26);
    check("ignore quotient",   32'(quotient),  32'hFFFFFF);
    check("ignore remainder",  32'(remainder), 32'd0);
    check("ignore idle busy",  32'(busy),      32'd0);

    // Reset during CALC: back to IDLE, outputs cleared, no done pulse.
    @(negedge clk);
    start     = 1'b1;
    is_signed = 1'b0;
    dividend  = 24'd1000;
    divisor   = 24'd10;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst busy",      32'(busy),      32'd0);
    check("midrst quotient",  32'(quotient),  32'd0);
    check("midrst remainder", 32'(remainder), 32'd0);
    check("midrst done",      32'(done),      32'd0);
    rst   = 1'b0;
    dones = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) dones++;
    end
    check("midrst no done", 32'(dones), 32'd0);
    do_op(1'b0, 24'd1000, 24'd10, lat, bcnt);
    check("post-rst latency",   32'(lat),       32'd26);
    check("post-rst quotient",  32'(quotient),  32'd100);
    check("post-rst remainder", 32'(remainder), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
